// File: rtl/bzmusic_beat_timer.sv
// Note-duration timer for the buzzer music player: converts a note length code
// and tempo unit into a millisecond countdown, returning one beat_finish pulse per note.
module bzmusic_beat_timer #(
    parameter int PRESC  = 50000,
    parameter int GAP_MS = 10,
    parameter int REM_W  = 12
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cnt_en,
    input  logic       cnt_rstn,
    input  logic [3:0] note_len,
    input  logic [7:0] unit_ms,
    input  logic       rest,
    output logic       beat_finish,
    output logic       mute,
    output logic       busy
);

    localparam int PW = $clog2(PRESC);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESC - 1);
    localparam logic [REM_W-1:0] GAP       = REM_W'(GAP_MS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             rest_q, rest_d;
    logic             beat_finish_q, beat_finish_d;
    logic             mute_q, mute_d;
    logic             busy_q, busy_d;

    // 5-bit length times 8-bit unit fits 13 bits before truncation to REM_W
    logic [7:0]  unit_eff;
    logic [12:0] total_ms;

    always_comb begin
        unit_eff = (unit_ms == 8'd0) ? 8'd1 : unit_ms;
        total_ms = ({9'd0, note_len} + 13'd1) * {5'd0, unit_eff};
    end

    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        rem_d         = rem_q;
        rest_d        = rest_q;
        beat_finish_d = 1'b0;

        if (!cnt_rstn) begin
            state_d = S_IDLE;
            presc_d = '0;
            rem_d   = '0;
            rest_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cnt_en) begin
                        state_d = S_RUN;
                        rem_d   = REM_W'(total_ms);
                        rest_d  = rest;
                        presc_d = '0;
                    end
                end
                S_RUN: begin
                    // cnt_en low pauses the note with everything held
                    if (cnt_en) begin
                        if (presc_q == PRESC_MAX) begin
                            presc_d = '0;
                            if (rem_q != '0) begin
                                rem_d = rem_q - REM_W'(1);
                            end
                            if (rem_q <= REM_W'(1)) begin
                                state_d       = S_DONE;
                                beat_finish_d = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_RUN);
        mute_d = (state_d != S_RUN) || rest_d || (rem_d <= GAP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            rem_q         <= '0;
            rest_q        <= 1'b0;
            beat_finish_q <= 1'b0;
            mute_q        <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            rem_q         <= rem_d;
            rest_q        <= rest_d;
            beat_finish_q <= beat_finish_d;
            mute_q        <= mute_d;
            busy_q        <= busy_d;
        end
    end

    assign beat_finish = beat_finish_q;
    assign mute        = mute_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_bzmusic_beat_timer.sv
// Directed bench for bzmusic_beat_timer with PRESC=4, GAP_MS=2; outputs are
// sampled on the falling edge, inputs driven there for the next rising edge.
module tb_bzmusic_beat_timer;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rstn;
    logic       cnt_en;
    logic       cnt_rstn;
    logic [3:0] note_len;
    logic [7:0] unit_ms;
    logic       rest;
    logic       beat_finish;
    logic       mute;
    logic       busy;

    int checks = 0;
    int errors = 0;

    bzmusic_beat_timer #(.PRESC(4), .GAP_MS(2), .REM_W(12)) dut (
        .clk(clk), .rstn(rstn), .cnt_en(cnt_en), .cnt_rstn(cnt_rstn),
        .note_len(note_len), .unit_ms(unit_ms), .rest(rest),
        .beat_finish(beat_finish), .mute(mute), .busy(busy)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Clear via cnt_rstn, then start a note; returns at the falling edge after RUN entry.
    task automatic start_note(input logic [3:0] len, input logic [7:0] unit, input logic r);
        cnt_en   = 1'b0;
        cnt_rstn = 1'b0;
        @(negedge clk);
        cnt_rstn = 1'b1;
        cnt_en   = 1'b1;
        note_len = len;
        unit_ms  = unit;
        rest     = r;
        @(negedge clk);
        // later input changes must be ignored during RUN
        note_len = 4'd15;
        unit_ms  = 8'd200;
        rest     = ~r;
    endtask

    task automatic test_reset();
        checks++;
        if ({beat_finish, mute, busy} !== 3'b010) begin
            errors++;
            $display("FAIL reset: {finish,mute,busy}=%b expected 010", {beat_finish, mute, busy});
        end
    endtask

    // Expects exactly 80 enabled cycles of RUN: mute low for 72, high for the last 8.
    task automatic test_basic(input string tag);
        start_note(4'd3, 8'd5, 1'b0);
        for (int k = 0; k < 80; k++) begin
            checks++;
            if ({beat_finish, mute, busy} !== {1'b0, (k >= 72), 1'b1}) begin
                errors++;
                $display("FAIL %s k=%0d: {finish,mute,busy}=%b expected %b", tag, k,
                         {beat_finish, mute, busy}, {1'b0, (k >= 72), 1'b1});
            end
            @(negedge clk);
        end
        checks++;
        if ({beat_finish, mute, busy} !== 3'b110) begin
            errors++;
            $display("FAIL %s finish: {finish,mute,busy}=%b expected 110", tag, {beat_finish, mute, busy});
        end
        for (int k = 0; k < 10; k++) begin
            cnt_en = k[0];
            @(negedge clk);
            checks++;
            if ({beat_finish, mute, busy} !== 3'b010) begin
                errors++;
                $display("FAIL %s done_hold k=%0d: {finish,mute,busy}=%b expected 010", tag, k,
                         {beat_finish, mute, busy});
            end
        end
    endtask

    // Pause for 13 edges (E74..E86); finish moves from edge 80 to 93.
    task automatic test_pause();
        int en;
        start_note(4'd3, 8'd5, 1'b0);
        for (int c = 0; c < 93; c++) begin
            en = c;
            if (c > 73) en = c - ((c - 73 > 13) ? 13 : (c - 73));
            checks++;
            if ({beat_finish, mute, busy} !== {1'b0, (en >= 72), 1'b1}) begin
                errors++;
                $display("FAIL pause c=%0d: {finish,mute,busy}=%b expected %b", c,
                         {beat_finish, mute, busy}, {1'b0, (en >= 72), 1'b1});
            end
            if (c == 73) cnt_en = 1'b0;
            if (c == 86) cnt_en = 1'b1;
            @(negedge clk);
        end
        checks++;
        if ({beat_finish, mute, busy} !== 3'b110) begin
            errors++;
            $display("FAIL pause finish: {finish,mute,busy}=%b expected 110", {beat_finish, mute, busy});
        end
    endtask

    // Short note: either a zero unit (1 ms) or a rest; mute high the whole time.
    task automatic test_short(input string tag, input logic [3:0] len, input logic [7:0] unit,
                              input logic r, input int cycles);
        start_note(len, unit, r);
        for (int k = 0; k < cycles; k++) begin
            checks++;
            if ({beat_finish, mute, busy} !== 3'b011) begin
                errors++;
                $display("FAIL %s k=%0d: {finish,mute,busy}=%b expected 011", tag, k,
                         {beat_finish, mute, busy});
            end
            @(negedge clk);
        end
        checks++;
        if ({beat_finish, mute, busy} !== 3'b110) begin
            errors++;
            $display("FAIL %s finish: {finish,mute,busy}=%b expected 110", tag, {beat_finish, mute, busy});
        end
    endtask

    // cnt_rstn low on the edge that would deliver the final tick.
    task automatic test_clear_on_tick();
        start_note(4'd3, 8'd5, 1'b0);
        repeat (79) @(negedge clk);
        cnt_rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({beat_finish, mute, busy} !== 3'b010) begin
            errors++;
            $display("FAIL clear_on_tick: {finish,mute,busy}=%b expected 010", {beat_finish, mute, busy});
        end
        cnt_en = 1'b0;
        cnt_rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({beat_finish, mute, busy} !== 3'b010) begin
                errors++;
                $display("FAIL clear_idle: {finish,mute,busy}=%b expected 010", {beat_finish, mute, busy});
            end
        end
        test_basic("restart");
    endtask

    task automatic test_async_reset();
        start_note(4'd3, 8'd5, 1'b0);
        repeat (20) @(negedge clk);
        clk_run = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({beat_finish, mute, busy} !== 3'b010) begin
            errors++;
            $display("FAIL async_reset: {finish,mute,busy}=%b expected 010", {beat_finish, mute, busy});
        end
        #5;
        rstn = 1'b1;
        #2;
        clk_run = 1'b1;
        @(negedge clk);
        test_basic("replay");
    endtask

    initial begin
        rstn     = 1'b0;
        cnt_en   = 1'b0;
        cnt_rstn = 1'b1;
        note_len = 4'd0;
        unit_ms  = 8'd0;
        rest     = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic("basic");
        test_pause();
        test_short("unit_zero", 4'd0, 8'd0, 1'b0, 4);
        test_short("rest", 4'd1, 8'd3, 1'b1, 24);
        test_clear_on_tick();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
